interval_timer_ctrl: RTL and testbench
======================================

// Module: interval_timer_ctrl
// PURPOSE
//  Sequencing controller for the free-running 8-bit counter datapath. Adds programmable load,
//  start/stop/hold control and one-shot or auto-reload modes. Reports terminal count (tc).
//  Sits between a CPU-side control register block and any logic that needs timed events.
// PARAMETERS
//  WIDTH      8    counter/load width in bits
// PORTS
//  clk          in   1      system clock; all state changes on posedge
//  reset        in   1      synchronous, active-high; overrides every other input
//  start        in   1      level-sampled; launches a count from load_val
//  stop         in   1      abort current count, return to IDLE
//  hold         in   1      level; freezes count while high in RUN
//  auto_reload  in   1      mode select, sampled only on accepted start (1=periodic)
//  load_val     in   WIDTH  start value, sampled only on accepted start
//  prescale     in   4      tick divider (present only with TIMER_PRESCALE_EN)
//  count        out  WIDTH  current counter value (registered)
//  busy         out  1      high in RUN or HOLD
//  tc           out  1      one-cycle pulse on terminal count
//  done         out  1      high while in DONE (one-shot completed)
// BEHAVIOUR
//  - Reset: state=IDLE, count=0, busy=0, tc=0, done=0; latched load/mode cleared.
//  - States: IDLE, RUN, HOLD, DONE. All outputs registered; tc defaults to 0 every cycle.
//  - IDLE/DONE + start, load_val!=0: count<=load_val, latch load_val+auto_reload -> RUN.
//    busy=1 and done=0 from the next edge. start with load_val==0: ignored, no state change.
//  - RUN: tick each cycle (see CONFIGURATION). On tick, count>1: count<=count-1.
//  - On tick, count==1, one-shot: count<=0, tc<=1, done<=1, busy<=0 -> DONE.
//  - On tick, count==1, auto_reload: count<=latched load, tc<=1, stay RUN.
//    Period is therefore exactly load ticks. No cycle spent at 0.
//  - hold=1 in RUN -> HOLD. Decrement suppressed in every cycle hold is high, including the first.
//  - hold=0 in HOLD -> RUN. The first decrement occurs on the next tick. busy stays 1 throughout.
//  - stop in RUN/HOLD/DONE -> IDLE: count retains value, busy=0, done=0, tc=0.
//  - Priority per cycle: reset > stop > hold > tick. stop together with a count==1 tick gives no tc.
//  - start while RUN/HOLD: ignored (no restart). start+stop in same cycle from IDLE/DONE: stop wins.
//  - Mode and load are frozen after start. Changing auto_reload/load_val mid-run has no effect.
//  - count never wraps below 0; no underflow path exists.
// CONFIGURATION
//  - TIMER_PRESCALE_EN defined: prescale port exists.
//    tick fires once every (prescale+1) clk cycles in RUN.
//    Internal 4-bit prescaler is cleared on accepted start and on entering IDLE/DONE.
//    It freezes in HOLD and is not cleared on auto-reload.
//  - Not defined: no prescale port, no prescaler logic; tick=1 every RUN cycle with hold=0.
// TESTING
//  1. reset, start load_val=5 one-shot -> count 5,4,3,2,1,0 on successive edges.
//     tc=1 only in the cycle count=0 appears; done=1, busy=0 after.
//  2. start load_val=3 auto_reload=1 -> count 3,2,1,3,2,1,3...
//     tc pulses every 3 cycles; busy stays 1; done stays 0.
//  3. load_val=10, hold high 4 cycles when count=6 -> count stays 6 for 4 cycles.
//     Then 5 on first cycle after hold drops; busy=1 throughout.
//  4. stop at count=1 in same cycle as tick -> IDLE, count=1, tc never asserted.
//     Then start with load_val=0 -> stays IDLE, count unchanged.
//  5. reset asserted in RUN at count=7 -> next edge count=0, busy=0, tc=0, done=0, IDLE.
//     Also: start during RUN -> ignored.
//  6. TIMER_PRESCALE_EN, prescale=2, load_val=2 one-shot -> count changes every 3 cycles.
//     tc fires 6 cycles after start is accepted.

Source files
------------

// File: rtl/interval_timer_ctrl.sv
// Programmable 8-bit interval timer: load/start/stop/hold sequencing, one-shot or auto-reload.
// Optional tick prescaler enabled by defining TIMER_PRESCALE_EN.
module interval_timer_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             hold,
    input  logic             auto_reload,
    input  logic [WIDTH-1:0] load_val,
`ifdef TIMER_PRESCALE_EN
    input  logic [3:0]       prescale,
`endif
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tc,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_count, w_count_nxt;
    logic [WIDTH-1:0] r_load,  w_load_nxt;
    logic             r_mode,  w_mode_nxt;
    logic             r_tc,    w_tc_nxt;
    logic             r_busy;
    logic             r_done;
    logic             w_tick;

`ifdef TIMER_PRESCALE_EN
    logic [3:0] r_pre, w_pre_nxt;
    logic       w_pre_clr;

    assign w_tick = (r_pre == prescale);

    // Prescaler wraps on each tick, freezes while held, restarts on start/IDLE/DONE.
    always_comb begin
        w_pre_nxt = r_pre;
        if (w_pre_clr)
            w_pre_nxt = '0;
        else if ((r_state == RUN || r_state == HOLD) && !stop && !hold)
            w_pre_nxt = w_tick ? 4'd0 : r_pre + 4'd1;
    end

    assign w_pre_clr = (w_state_nxt == IDLE) || (w_state_nxt == DONE) ||
                       ((r_state == IDLE || r_state == DONE) && w_state_nxt == RUN);

    always_ff @(posedge clk) begin
        if (reset) r_pre <= '0;
        else       r_pre <= w_pre_nxt;
    end
`else
    assign w_tick = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_count <= '0;
            r_load  <= '0;
            r_mode  <= 1'b0;
            r_tc    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_load  <= w_load_nxt;
            r_mode  <= w_mode_nxt;
            r_tc    <= w_tc_nxt;
            r_busy  <= (w_state_nxt == RUN) || (w_state_nxt == HOLD);
            r_done  <= (w_state_nxt == DONE);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_load_nxt  = r_load;
        w_mode_nxt  = r_mode;
        w_tc_nxt    = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (stop) begin
                    w_state_nxt = IDLE;
                end else if (start && load_val != '0) begin
                    w_state_nxt = RUN;
                    w_count_nxt = load_val;
                    w_load_nxt  = load_val;
                    w_mode_nxt  = auto_reload;
                end
            end
            RUN, HOLD: begin
                if (stop) begin
                    w_state_nxt = IDLE;
                end else if (hold) begin
                    w_state_nxt = HOLD;
                end else begin
                    // Releasing hold counts as a RUN cycle, so the tick may land here.
                    w_state_nxt = RUN;
                    if (w_tick) begin
                        if (r_count > WIDTH'(1)) begin
                            w_count_nxt = r_count - WIDTH'(1);
                        end else if (r_count == WIDTH'(1)) begin
                            w_tc_nxt = 1'b1;
                            if (r_mode) begin
                                w_count_nxt = r_load;
                            end else begin
                                w_count_nxt = '0;
                                w_state_nxt = DONE;
                            end
                        end
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign count = r_count;
    assign busy  = r_busy;
    assign tc    = r_tc;
    assign done  = r_done;

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// Directed self-checking bench for interval_timer_ctrl; expected values hand-computed.
module tb_interval_timer_ctrl;

    logic       clk = 1'b0;
    logic       reset, start, stop, hold, auto_reload;
    logic [7:0] load_val;
    logic [7:0] count;
    logic       busy, tc, done;
`ifdef TIMER_PRESCALE_EN
    logic [3:0] prescale;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    interval_timer_ctrl #(.WIDTH(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .hold        (hold),
        .auto_reload (auto_reload),
        .load_val    (load_val),
`ifdef TIMER_PRESCALE_EN
        .prescale    (prescale),
`endif
        .count       (count),
        .busy        (busy),
        .tc          (tc),
        .done        (done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] c, input logic b,
                           input logic t, input logic d);
        chk({tag, ".count"}, count, c);
        chk({tag, ".busy"},  {7'd0, busy}, {7'd0, b});
        chk({tag, ".tc"},    {7'd0, tc},   {7'd0, t});
        chk({tag, ".done"},  {7'd0, done}, {7'd0, d});
    endtask

    initial begin
        logic [7:0] exp_seq [7];
        reset = 1'b1; start = 1'b0; stop = 1'b0; hold = 1'b0;
        auto_reload = 1'b0; load_val = 8'd0;
`ifdef TIMER_PRESCALE_EN
        prescale = 4'd0;
`endif
        step(); step();
        chk_all("reset", 8'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        step();
        chk_all("idle", 8'd0, 1'b0, 1'b0, 1'b0);

        // One-shot from 5
        start = 1'b1; load_val = 8'd5; auto_reload = 1'b0;
        step();
        start = 1'b0;
        chk_all("os_start", 8'd5, 1'b1, 1'b0, 1'b0);
        for (int i = 4; i >= 1; i--) begin
            step();
            chk_all("os_run", 8'(i), 1'b1, 1'b0, 1'b0);
        end
        step();
        chk_all("os_tc", 8'd0, 1'b0, 1'b1, 1'b1);
        step();
        chk_all("os_done", 8'd0, 1'b0, 1'b0, 1'b1);

        // Auto-reload from 3, started from DONE; mid-run mode/load changes are ignored
        start = 1'b1; load_val = 8'd3; auto_reload = 1'b1;
        step();
        start = 1'b0; load_val = 8'd9; auto_reload = 1'b0;
        chk_all("ar_start", 8'd3, 1'b1, 1'b0, 1'b0);
        exp_seq = '{8'd2, 8'd1, 8'd3, 8'd2, 8'd1, 8'd3, 8'd2};
        for (int i = 0; i < 7; i++) begin
            step();
            chk_all("ar_run", exp_seq[i], 1'b1, exp_seq[i] == 8'd3, 1'b0);
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk_all("ar_stop", 8'd2, 1'b0, 1'b0, 1'b0);

        // Hold at 6 for four cycles
        start = 1'b1; load_val = 8'd10; auto_reload = 1'b0;
        step();
        start = 1'b0;
        chk_all("hd_start", 8'd10, 1'b1, 1'b0, 1'b0);
        for (int i = 9; i >= 6; i--) begin
            step();
            chk("hd_dec", count, 8'(i));
        end
        hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_all("hd_hold", 8'd6, 1'b1, 1'b0, 1'b0);
        end
        hold = 1'b0;
        step();
        chk_all("hd_release", 8'd5, 1'b1, 1'b0, 1'b0);
        step();
        chk("hd_after", count, 8'd4);

        // start while running is ignored
        start = 1'b1; load_val = 8'd20;
        step();
        start = 1'b0;
        chk_all("run_restart", 8'd3, 1'b1, 1'b0, 1'b0);
        step();
        chk("to_one_a", count, 8'd2);
        step();
        chk("to_one_b", count, 8'd1);

        // stop coinciding with the terminal tick suppresses tc
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk_all("stop_tc", 8'd1, 1'b0, 1'b0, 1'b0);
        step();
        chk_all("stop_idle", 8'd1, 1'b0, 1'b0, 1'b0);
        start = 1'b1; load_val = 8'd0;
        step();
        start = 1'b0;
        chk_all("start_zero", 8'd1, 1'b0, 1'b0, 1'b0);

        // Reset mid-run
        start = 1'b1; load_val = 8'd9;
        step();
        start = 1'b0;
        step(); step();
        chk_all("pre_reset", 8'd7, 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_all("mid_reset", 8'd0, 1'b0, 1'b0, 1'b0);

        // start+stop together from IDLE: stop wins
        start = 1'b1; stop = 1'b1; load_val = 8'd4;
        step();
        start = 1'b0; stop = 1'b0;
        chk_all("start_stop", 8'd0, 1'b0, 1'b0, 1'b0);

        // One-shot of 1: terminal on first tick
        start = 1'b1; load_val = 8'd1;
        step();
        start = 1'b0;
        chk_all("one_start", 8'd1, 1'b1, 1'b0, 1'b0);
        step();
        chk_all("one_tc", 8'd0, 1'b0, 1'b1, 1'b1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk_all("done_stop", 8'd0, 1'b0, 1'b0, 1'b0);

`ifdef TIMER_PRESCALE_EN
        prescale = 4'd2;
        start = 1'b1; load_val = 8'd2;
        step();
        start = 1'b0;
        chk_all("ps_start", 8'd2, 1'b1, 1'b0, 1'b0);
        exp_seq = '{8'd2, 8'd2, 8'd1, 8'd1, 8'd1, 8'd0, 8'd0};
        for (int i = 0; i < 6; i++) begin
            step();
            chk_all("ps_run", exp_seq[i], i < 5, i == 5, i == 5);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
